stump_control_unit: RTL and testbench
=====================================

Name: stump_control_unit

Overview:
- Next-generation Stump control block: merges the FETCH/EXECUTE/MEMORY state register with instruction decode in one module.
- Adds four things the combinational decoder lacked:
  - memory wait-state handshake (mem_ready);
  - bus-timeout detection;
  - HALT state with external halt/resume control;
  - retired-instruction counter.
- Sits between the IR/CC registers and the Stump datapath (register bank, shifter, ALU, memory interface). Replaces the separate state flop and combinational decoder.

Parameters:
- PC_REG, 7: register index used as program counter.
- CNT_W, 16: width of the retired-instruction counter.
- WAIT_TIMEOUT, 15: maximum wait cycles on mem_ready before bus error; 0 disables the timeout.
- WAIT_W, 4: width of the wait counter; must hold WAIT_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ir  in  16  current instruction register.
- cc  in  4  condition codes {N,Z,V,C}.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- halt_req  in  1  request to stop at the next instruction boundary (level).
- resume  in  1  leave HALT (single-cycle pulse).
- fetch, execute, memory, halted  out  1 each  one-hot state indicators.
- ir_en  out  1  load IR from memory read data.
- ext_op  out  1  select sign-extended immediate path.
- reg_write  out  1  register-bank write enable.
- dest, srcA, srcB  out  3 each  register addresses.
- shift_op  out  2  shifter operation.
- opB_mux_sel  out  1  0 = register B, 1 = immediate.
- alu_func  out  3  ALU function.
- cc_en  out  1  CC register enable.
- mem_ren, mem_wen  out  1 each  memory strobes.
- bus_error  out  1  sticky timeout flag.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register: 2 bits, encodings FETCH=00, EXECUTE=01, MEMORY=10, HALT=11.
- Reset (rst=0, asynchronous) forces immediately, mid-operation included:
  - state=FETCH, wait_cnt=0, bus_error=0, instr_count=0.
  - Outputs then follow the FETCH decode below.
- Decode outputs are combinational from state, ir, cc and mem_ready. Every output is driven to a defined value (no x) in every state: srcB=0, shift_op=00, opB_mux_sel=0, ext_op=0 wherever they are not used.
- FETCH:
  - mem_ren=1; srcA=dest=PC_REG; alu_func=ADD(000); cc_en=0.
  - reg_write=ir_en=mem_ready.
  - mem_ready=1 -> EXECUTE. Otherwise stay in FETCH and increment wait_cnt.
- EXECUTE:
  - Opcode ir[15:13]. Type bit ir[12]: 1 = register form, 0 = immediate form.
  - Non-BCC: dest=ir[10:8], srcA=ir[7:5], alu_func=ir[15:13].
    - Type 1: srcB=ir[4:2], shift_op=ir[1:0], opB_mux_sel=0, ext_op=0.
    - Type 0: opB_mux_sel=1, ext_op=1.
    - Non-LDST: cc_en=ir[11], reg_write=1.
    - LDST (011): reg_write=0, cc_en=0; the address is computed this cycle; next state MEMORY.
  - BCC (111): ext_op=1, opB_mux_sel=1, srcA=dest=PC_REG, alu_func=ADD, cc_en=0.
    - reg_write = branch-taken(ir[11:8], cc), using the standard 16-condition Stump table (0 always … 15 (N^V)|Z).
  - Non-LDST exit: halt_req=1 -> HALT, else FETCH. The instruction retires.
- MEMORY:
  - mem_ren=~ir[11], mem_wen=ir[11], dest=ir[10:8].
  - reg_write = ~ir[11] & mem_ready (load write-back). cc_en=0.
  - mem_ready=1 -> retire; halt_req ? HALT : FETCH.
  - Otherwise stay in MEMORY and increment wait_cnt.
- HALT:
  - All enables and strobes 0; halted=1.
  - resume=1 -> FETCH. resume with halt_req still high still goes to FETCH; the halt is re-taken at the next boundary.
- wait_cnt:
  - Clears on every state transition.
  - In FETCH/MEMORY, when WAIT_TIMEOUT≠0 and wait_cnt==WAIT_TIMEOUT with mem_ready=0: set bus_error, go to HALT, no retire.
  - mem_ready arriving in that same cycle wins: normal completion.
- bus_error clears only on reset.
- instr_count:
  - Increments by 1 on each retire; wraps from 2^CNT_W−1 to 0.
  - A retire and entry to HALT in the same cycle still count.

Decomposition:
- Shared Stump definitions package holds: state encodings, opcodes (ADD, LDST, BCC), and condition-code bit positions.
- Natural sub-module: stump_branch_eval (combinational, 4-bit condition + 4-bit cc -> taken).
- The FSM and counters remain in stump_control_unit.

Test Plan:
- Reset: rst low mid-MEMORY with wait pending -> immediately fetch=1, instr_count=0, bus_error=0; outputs hold through rst release.
- ADD register form: ir=16'h1A44 (ADD, S=1, R2<=R2+R1), fetch with mem_ready=1 -> next cycle execute=1, dest=2, srcA=2, srcB=1, cc_en=1, reg_write=1; instr_count 0->1.
- Load with 3 wait cycles: ir=16'h6000 type-0 LD -> EXECUTE reg_write=0; MEMORY mem_ren=1 for 4 cycles; reg_write=1 only in the mem_ready cycle; then FETCH.
- Branch: BCC cond 7 (EQ) with cc=4'b0100 -> reg_write=1, dest=7. Same instruction with cc=0 -> reg_write=0.
- Timeout: WAIT_TIMEOUT=15, mem_ready held low in FETCH -> after 16 FETCH cycles bus_error=1, halted=1; resume -> FETCH with bus_error still 1.
- Halt and counter wrap: halt_req high during an ADD -> HALT after EXECUTE, count incremented. With CNT_W=4 and 16 retires -> instr_count wraps to 0.

Source files
------------

// File: rtl/stump_control_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : stump_control_unit_pkg                                   |
// | Purpose : Shared Stump definitions: control-state encodings,       |
// |           opcodes used by the control unit and the bit positions   |
// |           of the condition codes inside cc = {N,Z,V,C}.            |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package stump_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_LDST = 3'b011;
    localparam logic [2:0] C_OP_BCC  = 3'b111;

    localparam int C_CC_N = 3;
    localparam int C_CC_Z = 2;
    localparam int C_CC_V = 1;
    localparam int C_CC_C = 0;

endpackage
`default_nettype wire

// File: rtl/stump_branch_eval.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : stump_branch_eval                                        |
// | Purpose : Evaluates the 16 Stump branch conditions against the     |
// |           current condition codes.                                 |
// | Ports   : i_cond  [3:0] condition field of the BCC instruction     |
// |           i_cc    [3:0] condition codes {N,Z,V,C}                  |
// |           o_taken       1 when the branch is taken                 |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module stump_branch_eval
    import stump_control_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_cc,
    output logic       o_taken
);

    logic w_n;
    logic w_z;
    logic w_v;
    logic w_c;

    assign w_n = i_cc[C_CC_N];
    assign w_z = i_cc[C_CC_Z];
    assign w_v = i_cc[C_CC_V];
    assign w_c = i_cc[C_CC_C];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            4'd0:  o_taken = 1'b1;                    // AL
            4'd1:  o_taken = 1'b0;                    // NV
            4'd2:  o_taken = ~(w_c | w_z);            // HI
            4'd3:  o_taken = w_c | w_z;               // LS
            4'd4:  o_taken = ~w_c;                    // CC
            4'd5:  o_taken = w_c;                     // CS
            4'd6:  o_taken = ~w_z;                    // NE
            4'd7:  o_taken = w_z;                     // EQ
            4'd8:  o_taken = ~w_v;                    // VC
            4'd9:  o_taken = w_v;                     // VS
            4'd10: o_taken = ~w_n;                    // PL
            4'd11: o_taken = w_n;                     // MI
            4'd12: o_taken = ~(w_n ^ w_v);            // GE
            4'd13: o_taken = w_n ^ w_v;               // LT
            4'd14: o_taken = ~((w_n ^ w_v) | w_z);    // GT
            default: o_taken = (w_n ^ w_v) | w_z;     // LE
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stump_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : stump_control_unit                                       |
// | Purpose : Stump FETCH/EXECUTE/MEMORY/HALT sequencer merged with    |
// |           instruction decode, memory wait handshake, bus timeout   |
// |           and retired-instruction counter.                         |
// | Ports   : clk, rst (async, active-low)                             |
// |           ir[15:0], cc[3:0], mem_ready, halt_req, resume (inputs)  |
// |           fetch/execute/memory/halted one-hot state indicators     |
// |           ir_en, ext_op, reg_write, dest, srcA, srcB, shift_op,    |
// |           opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen           |
// |           bus_error (sticky), instr_count[CNT_W-1:0]               |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module stump_control_unit
    import stump_control_unit_pkg::*;
#(
    parameter int PC_REG       = 7,
    parameter int CNT_W        = 16,
    parameter int WAIT_TIMEOUT = 15,
    parameter int WAIT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ir,
    input  logic [3:0]       cc,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             fetch,
    output logic             execute,
    output logic             memory,
    output logic             halted,
    output logic             ir_en,
    output logic             ext_op,
    output logic             reg_write,
    output logic [2:0]       dest,
    output logic [2:0]       srcA,
    output logic [2:0]       srcB,
    output logic [1:0]       shift_op,
    output logic             opB_mux_sel,
    output logic [2:0]       alu_func,
    output logic             cc_en,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0]        C_PC         = 3'(PC_REG);
    localparam logic [WAIT_W-1:0] C_TIMEOUT    = WAIT_W'(WAIT_TIMEOUT);
    localparam logic              C_TIMEOUT_EN = (WAIT_TIMEOUT != 0);

    state_e            state_q,       state_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              bus_error_q,   bus_error_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;

    logic [2:0] w_opcode;
    logic       w_taken;
    logic       w_timeout;
    logic       w_retire;

    assign w_opcode = ir[15:13];

    // Only meaningful in FETCH/MEMORY; a mem_ready in the same cycle wins.
    assign w_timeout = C_TIMEOUT_EN && (wait_cnt_q == C_TIMEOUT) && !mem_ready;

    stump_branch_eval u_branch_eval (
        .i_cond  (ir[11:8]),
        .i_cc    (cc),
        .o_taken (w_taken)
    );

    always_comb begin
        ir_en       = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        dest        = 3'd0;
        srcA        = 3'd0;
        srcB        = 3'd0;
        shift_op    = 2'b00;
        opB_mux_sel = 1'b0;
        alu_func    = C_OP_ADD;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        state_d     = state_q;
        bus_error_d = bus_error_q;
        w_retire    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_ren   = 1'b1;
                srcA      = C_PC;
                dest      = C_PC;
                reg_write = mem_ready;   // PC increment lands with the fetch
                ir_en     = mem_ready;
                if (mem_ready) begin
                    state_d = ST_EXECUTE;
                end else if (w_timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_EXECUTE: begin
                if (w_opcode == C_OP_BCC) begin
                    ext_op      = 1'b1;
                    opB_mux_sel = 1'b1;
                    srcA        = C_PC;
                    dest        = C_PC;
                    reg_write   = w_taken;
                end else begin
                    dest     = ir[10:8];
                    srcA     = ir[7:5];
                    alu_func = w_opcode;
                    if (ir[12]) begin
                        srcB     = ir[4:2];
                        shift_op = ir[1:0];
                    end else begin
                        opB_mux_sel = 1'b1;
                        ext_op      = 1'b1;
                    end
                    if (w_opcode != C_OP_LDST) begin
                        cc_en     = ir[11];
                        reg_write = 1'b1;
                    end
                end
                // Loads/stores only compute their address here and retire later.
                if (w_opcode == C_OP_LDST) begin
                    state_d = ST_MEMORY;
                end else begin
                    w_retire = 1'b1;
                    state_d  = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_MEMORY: begin
                mem_ren   = ~ir[11];
                mem_wen   = ir[11];
                dest      = ir[10:8];
                reg_write = ~ir[11] & mem_ready;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    state_d  = halt_req ? ST_HALT : ST_FETCH;
                end else if (w_timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            default: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
        endcase

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_FETCH) || (state_q == ST_MEMORY)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end

        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, w_retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FETCH;
            wait_cnt_q    <= '0;
            bus_error_q   <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_error_q   <= bus_error_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign fetch       = (state_q == ST_FETCH);
    assign execute     = (state_q == ST_EXECUTE);
    assign memory      = (state_q == ST_MEMORY);
    assign halted      = (state_q == ST_HALT);
    assign bus_error   = bus_error_q;
    assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stump_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_stump_control_unit                                    |
// | Purpose : Self-checking bench for stump_control_unit: directed     |
// |           scenarios plus random instruction/handshake traffic      |
// |           compared against a behavioural model of the control unit.|
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_stump_control_unit;

    localparam int PC_REG       = 7;
    localparam int CNT_W        = 4;
    localparam int WAIT_TIMEOUT = 15;
    localparam int WAIT_W       = 4;

    localparam int S_F = 0;
    localparam int S_E = 1;
    localparam int S_M = 2;
    localparam int S_H = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [15:0]      ir;
    logic [3:0]       cc;
    logic             mem_ready, halt_req, resume;
    logic             fetch, execute, memory, halted;
    logic             ir_en, ext_op, reg_write, opB_mux_sel, cc_en, mem_ren, mem_wen, bus_error;
    logic [2:0]       dest, srcA, srcB, alu_func;
    logic [1:0]       shift_op;
    logic [CNT_W-1:0] instr_count;

    stump_control_unit #(
        .PC_REG       (PC_REG),
        .CNT_W        (CNT_W),
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .WAIT_W       (WAIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ir          (ir),
        .cc          (cc),
        .mem_ready   (mem_ready),
        .halt_req    (halt_req),
        .resume      (resume),
        .fetch       (fetch),
        .execute     (execute),
        .memory      (memory),
        .halted      (halted),
        .ir_en       (ir_en),
        .ext_op      (ext_op),
        .reg_write   (reg_write),
        .dest        (dest),
        .srcA        (srcA),
        .srcB        (srcB),
        .shift_op    (shift_op),
        .opB_mux_sel (opB_mux_sel),
        .alu_func    (alu_func),
        .cc_en       (cc_en),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .bus_error   (bus_error),
        .instr_count (instr_count)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state
    int m_state, m_wait, m_cnt;
    bit m_berr;
    // Next-state and expected outputs for the current cycle
    int n_state, n_wait, n_cnt;
    bit n_berr;
    bit e_ir_en, e_ext, e_rw, e_opb, e_cc_en, e_ren, e_wen;
    int e_dest, e_srcA, e_srcB, e_shift, e_alu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Branch conditions come in complementary pairs: odd codes invert the even one.
    function automatic bit ref_taken(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, v, c;
        bit base [8];
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        base = '{1'b1, !(c | z), !c, !z, !v, !n, !(n ^ v), !((n ^ v) | z)};
        return base[cond[3:1]] ^ cond[0];
    endfunction

    task automatic model_reset();
        m_state = S_F; m_wait = 0; m_berr = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        bit retire, tmo;
        int op;
        e_ir_en = 0; e_ext = 0; e_rw = 0; e_opb = 0; e_cc_en = 0; e_ren = 0; e_wen = 0;
        e_dest = 0; e_srcA = 0; e_srcB = 0; e_shift = 0; e_alu = 0;
        n_state = m_state; n_berr = m_berr; retire = 0;
        op  = int'(ir[15:13]);
        tmo = (m_wait == WAIT_TIMEOUT) && !mem_ready;
        if (m_state == S_F) begin
            e_ren = 1; e_srcA = PC_REG; e_dest = PC_REG;
            e_rw = mem_ready; e_ir_en = mem_ready;
            if (mem_ready) n_state = S_E;
            else if (tmo) begin n_state = S_H; n_berr = 1; end
        end else if (m_state == S_E) begin
            if (op == 7) begin
                e_ext = 1; e_opb = 1; e_srcA = PC_REG; e_dest = PC_REG;
                e_rw = ref_taken(ir[11:8], cc);
            end else begin
                e_dest = int'(ir[10:8]); e_srcA = int'(ir[7:5]); e_alu = op;
                if (ir[12]) begin e_srcB = int'(ir[4:2]); e_shift = int'(ir[1:0]); end
                else begin e_opb = 1; e_ext = 1; end
                if (op != 3) begin e_cc_en = ir[11]; e_rw = 1; end
            end
            if (op == 3) n_state = S_M;
            else begin retire = 1; n_state = halt_req ? S_H : S_F; end
        end else if (m_state == S_M) begin
            e_ren = !ir[11]; e_wen = ir[11]; e_dest = int'(ir[10:8]);
            e_rw = !ir[11] && mem_ready;
            if (mem_ready) begin retire = 1; n_state = halt_req ? S_H : S_F; end
            else if (tmo) begin n_state = S_H; n_berr = 1; end
        end else begin
            if (resume) n_state = S_F;
        end
        if (n_state != m_state) n_wait = 0;
        else if (m_state == S_F || m_state == S_M) n_wait = m_wait + 1;
        else n_wait = 0;
        n_cnt = (m_cnt + (retire ? 1 : 0)) % (1 << CNT_W);
    endtask

    task automatic check_outputs();
        chk("fetch",   32'(fetch),   32'(m_state == S_F));
        chk("execute", 32'(execute), 32'(m_state == S_E));
        chk("memory",  32'(memory),  32'(m_state == S_M));
        chk("halted",  32'(halted),  32'(m_state == S_H));
        chk("ir_en",   32'(ir_en),   32'(e_ir_en));
        chk("reg_write", 32'(reg_write), 32'(e_rw));
        chk("mem_ren", 32'(mem_ren), 32'(e_ren));
        chk("mem_wen", 32'(mem_wen), 32'(e_wen));
        chk("cc_en",   32'(cc_en),   32'(e_cc_en));
        chk("ext_op",  32'(ext_op),  32'(e_ext));
        chk("opB_mux_sel", 32'(opB_mux_sel), 32'(e_opb));
        chk("srcB",    32'(srcB),    32'(e_srcB));
        chk("shift_op", 32'(shift_op), 32'(e_shift));
        chk("bus_error", 32'(bus_error), 32'(m_berr));
        chk("instr_count", 32'(instr_count), 32'(m_cnt));
        if (m_state == S_F || m_state == S_E) begin
            chk("srcA", 32'(srcA), 32'(e_srcA));
            chk("alu_func", 32'(alu_func), 32'(e_alu));
        end
        if (m_state != S_H) chk("dest", 32'(dest), 32'(e_dest));
    endtask

    // One clock: drive at the falling edge, check, advance model on the rising edge.
    task automatic step(input logic [15:0] t_ir, input logic [3:0] t_cc,
                        input logic t_mr, input logic t_hr, input logic t_res);
        ir = t_ir; cc = t_cc; mem_ready = t_mr; halt_req = t_hr; resume = t_res;
        #1;
        model_eval();
        check_outputs();
        @(posedge clk);
        if (rst) begin
            m_state = n_state; m_wait = n_wait; m_berr = n_berr; m_cnt = n_cnt;
        end
        @(negedge clk);
    endtask

    // Asserts reset between clock edges, away from any posedge.
    task automatic async_reset_mid();
        #3 rst = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ir = 16'h0; cc = 4'h0; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
        model_reset();
        @(negedge clk);

        phase = "reset";
        step(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;

        phase = "add_reg";
        step(16'h1A44, 4'h0, 1'b1, 1'b0, 1'b0);
        step(16'h1A44, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("add_retired", 32'(instr_count), 32'd1);

        phase = "load_wait";
        step(16'h6000, 4'h0, 1'b1, 1'b0, 1'b0);
        step(16'h6000, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(16'h6000, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h6000, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("load_back_to_fetch", 32'(fetch), 32'd1);

        phase = "branch";
        step(16'hE700, 4'b0100, 1'b1, 1'b0, 1'b0);
        ir = 16'hE700; cc = 4'b0100; #1;
        chk("beq_taken_rw", 32'(reg_write), 32'd1);
        chk("beq_dest", 32'(dest), 32'd7);
        step(16'hE700, 4'b0100, 1'b0, 1'b0, 1'b0);
        step(16'hE700, 4'b0000, 1'b1, 1'b0, 1'b0);
        ir = 16'hE700; cc = 4'b0000; #1;
        chk("beq_not_taken_rw", 32'(reg_write), 32'd0);
        step(16'hE700, 4'b0000, 1'b0, 1'b0, 1'b0);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            step(16'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
        end

        phase = "reset_mid_mem";
        for (int i = 0; i < 4 && m_state != S_F; i++) step(16'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(16'h6900, 4'h0, 1'b1, 1'b0, 1'b0);
        step(16'h6900, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h6900, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h6900, 4'h0, 1'b0, 1'b0, 1'b0);
        async_reset_mid();
        chk("rst_fetch", 32'(fetch), 32'd1);
        step(16'h6900, 4'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;

        phase = "timeout";
        for (int i = 0; i < 16; i++) step(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("timeout_halted", 32'(halted), 32'd1);
        chk("timeout_berr", 32'(bus_error), 32'd1);
        step(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        phase = "halt_wrap";
        async_reset_mid();
        step(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(16'h1A44, 4'h0, 1'b1, 1'b0, 1'b0);
            step(16'h1A44, 4'h0, 1'b1, (i == 15), 1'b0);
        end
        chk("wrap_count", 32'(instr_count), 32'd0);
        chk("halt_after_exec", 32'(halted), 32'd1);
        step(16'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        step(16'h1A44, 4'h0, 1'b1, 1'b1, 1'b0);
        step(16'h1A44, 4'h0, 1'b1, 1'b1, 1'b0);
        step(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
